// File: rtl/vga_scan_gen.sv
// Raster scan generator and registered pixel output stage.
// Owns the horizontal/vertical counters that drive x/y to the overlay blocks.
// Samples the combinational overlay hit in the same cycle as x/y, then registers
// colour and syncs together so they leave the chip mutually aligned.
// Also keeps the frame counter and frame strobe that pace the animation.

module vga_scan_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [5:0]  FG_COLOR = 6'b111111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       overlay_active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic [9:0] frame,
  output logic       frame_strobe
);

  // Totals must fit the 10-bit counters (<= 1024).
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 10-bit copies of the timing points so every compare is width-matched.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_STOP    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_STOP    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;

  logic       visible;
  logic       hsync_d;
  logic       vsync_d;
  logic [5:0] pixel_d;

  assign h_wrap     = (h_cnt == H_LAST);
  assign v_wrap     = (v_cnt == V_LAST);
  assign frame_wrap = h_wrap && v_wrap;

  // Coordinates come straight from the counter flops so they are glitch-free.
  assign x = h_cnt;
  assign y = v_cnt;

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Decode sync windows, visibility and the pixel colour for the current counters.
  always_comb begin
    visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync_d = !((h_cnt >= HS_START) && (h_cnt < HS_STOP));
    vsync_d = !((v_cnt >= VS_START) && (v_cnt < VS_STOP));
    pixel_d = '0;
    if (visible) begin
      // Overlay hit is only honoured inside the visible area.
      if (overlay_active) begin
        pixel_d = FG_COLOR;
      end else begin
        pixel_d = {h_cnt[8:7], v_cnt[8:7], frame[7:6]};
      end
    end
  end

  // Output stage: syncs, visibility and colour share one register so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      display_on <= 1'b0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
    end else begin
      hsync      <= hsync_d;
      vsync      <= vsync_d;
      display_on <= visible;
      {r, g, b}  <= pixel_d;
    end
  end

  // Frame counter and strobe; the strobe lands in the cycle that presents (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame        <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= frame_wrap;
      if (frame_wrap) begin
        frame <= frame + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: one full-size instance for horizontal and colour checks,
// one reduced-timing instance so vertical timing and frame wraps fit a short run.
// A cycle-count reference model checks both instances on every falling edge.

module tb_vga_scan_gen;

  // Instance A: standard 640x480 timing.
  localparam int HA_A = 640, HFP_A = 16, HS_A = 96, HBP_A = 48;
  localparam int VA_A = 480, VFP_A = 10, VS_A = 2, VBP_A = 33;
  // Instance B: short lines, tall-enough frame to reach y >= 256.
  localparam int HA_B = 8, HFP_B = 2, HS_B = 3, HBP_B = 3;
  localparam int VA_B = 300, VFP_B = 5, VS_B = 2, VBP_B = 3;
  localparam int HT_B = HA_B + HFP_B + HS_B + HBP_B;
  localparam int VT_B = VA_B + VFP_B + VS_B + VBP_B;
  localparam int FT_B = HT_B * VT_B;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic [9:0] fr;
    logic       st;
  } obs_t;

  typedef struct {
    int         hx;
    int         vy;
    logic       ov;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       de;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, ov_a, ov_b;
  logic ovp_a, ovp_b;
  logic [9:0] x_a, y_a, fr_a, x_b, y_b, fr_b;
  logic hs_a, vs_a, de_a, st_a, hs_b, vs_b, de_b, st_b;
  logic [1:0] r_a, g_a, b_a, r_b, g_b, b_b;
  obs_t obs_a, obs_b, exp_a, exp_b, rst_e;

  int n_a = 0, n_b = 0;
  int off_a = 0, off_b = 0;
  int checks = 0, fails = 0;
  int strobe_cnt = 0;
  bit a_rand = 0, b_rand = 0, done = 0;

  always #5 clk = ~clk;

  vga_scan_gen dut_a (
    .clk(clk), .rst_n(rst_a), .overlay_active(ov_a), .x(x_a), .y(y_a),
    .hsync(hs_a), .vsync(vs_a), .display_on(de_a), .r(r_a), .g(g_a), .b(b_a),
    .frame(fr_a), .frame_strobe(st_a)
  );

  vga_scan_gen #(
    .H_ACTIVE(HA_B), .H_FP(HFP_B), .H_SYNC(HS_B), .H_BP(HBP_B),
    .V_ACTIVE(VA_B), .V_FP(VFP_B), .V_SYNC(VS_B), .V_BP(VBP_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .overlay_active(ov_b), .x(x_b), .y(y_b),
    .hsync(hs_b), .vsync(vs_b), .display_on(de_b), .r(r_b), .g(g_b), .b(b_b),
    .frame(fr_b), .frame_strobe(st_b)
  );

  assign obs_a = {x_a, y_a, hs_a, vs_a, de_a, r_a, g_a, b_a, fr_a, st_a};
  assign obs_b = {x_b, y_b, hs_b, vs_b, de_b, r_b, g_b, b_b, fr_b, st_b};

  // Elapsed edges since reset release, and the overlay value each edge sampled.
  always @(posedge clk or negedge rst_a) if (!rst_a) n_a <= 0; else n_a <= n_a + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) n_b <= 0; else n_b <= n_b + 1;
  always @(posedge clk) begin
    ovp_a <= ov_a;
    ovp_b <= ov_b;
  end

  // Expected outputs after n edges, from the raster arithmetic alone.
  function automatic obs_t model(input int n, input int ha, input int hfp, input int hsw,
                                 input int hbp, input int va, input int vfp, input int vsw,
                                 input int vbp, input int off, input logic ov);
    int ht, vt, ft, p, px, py, pf;
    obs_t e;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    ft = ht * vt;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (n == 0) return e;
    e.x  = 10'(n % ht);
    e.y  = 10'((n / ht) % vt);
    e.fr = 10'((n / ft + off) % 1024);
    e.st = (n % ft == 0);
    p  = n - 1;
    px = p % ht;
    py = (p / ht) % vt;
    pf = (p / ft + off) % 1024;
    e.hs = !(px >= ha + hfp && px < ha + hfp + hsw);
    e.vs = !(py >= va + vfp && py < va + vfp + vsw);
    e.de = (px < ha) && (py < va);
    if (e.de) begin
      if (ov) begin
        e.r = 2'd3; e.g = 2'd3; e.b = 2'd3;
      end else begin
        e.r = 2'((px / 128) % 4);
        e.g = 2'((py / 128) % 4);
        e.b = 2'((pf / 64) % 4);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Step falling edges until the chosen instance presents (hx, vy), bounded.
  task automatic wait_xy(input bit sel, input int hx, input int vy, input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      if (sel ? (x_b == 10'(hx) && y_b == 10'(vy)) : (x_a == 10'(hx) && y_a == 10'(vy)))
        found = 1;
      else
        @(negedge clk);
    end
    if (!found) chk($sformatf("wait_xy[%0d] x=%0d y=%0d timeout", sel, hx, vy), 40'd0, 40'd1);
  endtask

  // Measure a sync that has just been seen falling: low width and fall-to-fall period.
  task automatic measure(input bit sel, input int limit, output int low, output int per);
    bit seen_hi = 0;
    logic s;
    low = 1;
    per = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      per++;
      s = sel ? vs_b : hs_a;
      if (!seen_hi) begin
        if (s) seen_hi = 1; else low++;
      end else if (!s) begin
        break;
      end
    end
  endtask

  task automatic seq_a();
    vec_t tbl[8];
    int low, per;
    tbl[0] = '{100, 0, 1'b1, 2'd3, 2'd3, 2'd3, 1'b1};
    tbl[1] = '{384, 0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1};
    tbl[2] = '{700, 0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[3] = '{130, 1, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1};
    tbl[4] = '{200, 1, 1'b1, 2'd3, 2'd3, 2'd3, 1'b1};
    tbl[5] = '{639, 1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1};
    tbl[6] = '{640, 1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[7] = '{256, 2, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      wait_xy(0, tbl[i].hx, tbl[i].vy, 2000);
      ov_a = tbl[i].ov;
      @(posedge clk);
      #1;
      chk($sformatf("table[%0d] rgb_de", i), {r_a, g_a, b_a, de_a},
          {tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].de});
      ov_a = 1'b0;
      @(negedge clk);
    end
    a_rand = 1;
    // Horizontal sync: falls on the edge after x=656, 96 low, 800 period.
    wait_xy(0, 656, 3, 3000);
    chk("hsync_before_fall", 40'(hs_a), 40'd1);
    @(negedge clk);
    chk("hsync_fall", 40'(hs_a), 40'd0);
    measure(0, 2000, low, per);
    chk("hsync_low_width", 40'(low), 40'd96);
    chk("hsync_period", 40'(per), 40'd800);
    // Asynchronous reset mid-line, away from any clock edge.
    wait_xy(0, 300, 5, 2000);
    #2 rst_a = 1'b0;
    #1 chk("reset_mid_a", obs_a, rst_e);
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_x", 40'(x_a), 40'd1);
    chk("post_reset_hsync", 40'(hs_a), 40'd1);
    chk("post_reset_display_on", 40'(de_a), 40'd1);
    repeat (200) @(negedge clk);
  endtask

  task automatic seq_b();
    int low, per;
    b_rand = 1;
    // Vertical sync: falls one cycle after (0, V_ACTIVE+V_FP).
    wait_xy(1, 0, VA_B + VFP_B, 6000);
    chk("vsync_before_fall", 40'(vs_b), 40'd1);
    @(negedge clk);
    chk("vsync_fall", 40'(vs_b), 40'd0);
    measure(1, 2 * FT_B, low, per);
    chk("vsync_low_width", 40'(low), 40'(VS_B * HT_B));
    chk("vsync_period", 40'(per), 40'(FT_B));
    // Two whole frames after reset.
    for (int i = 0; i < FT_B && n_b != 2 * FT_B; i++) @(negedge clk);
    #1;
    chk("frame_after_two", 40'(fr_b), 40'd2);
    chk("strobe_count_two", 40'(strobe_cnt), 40'd2);
    // Background colour with frame = 128 at y = 256.
    force dut_b.frame = 10'd128;
    off_b = 128 - n_b / FT_B;
    b_rand = 0;
    ov_b = 1'b0;
    #1 release dut_b.frame;
    wait_xy(1, 3, 256, FT_B);
    @(posedge clk);
    #1;
    chk("background_rgb_de", {r_b, g_b, b_b, de_b}, {2'd0, 2'd2, 2'd2, 1'b1});
    @(negedge clk);
    b_rand = 1;
    // Frame counter wrap 1023 -> 0 with strobe.
    for (int i = 0; i < 2 * FT_B && n_b != 3 * FT_B - 2; i++) @(negedge clk);
    #1 force dut_b.frame = 10'd1023;
    off_b = 1023 - n_b / FT_B;
    #1 release dut_b.frame;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("wrap_frame", 40'(fr_b), 40'd0);
    chk("wrap_strobe", 40'(st_b), 40'd1);
    chk("wrap_xy", {x_b, y_b}, 40'd0);
    @(posedge clk);
    #1;
    chk("strobe_one_cycle", 40'(st_b), 40'd0);
    chk("frame_hold", 40'(fr_b), 40'd0);
    repeat (100) @(negedge clk);
  endtask

  initial begin
    rst_e = '0;
    rst_e.hs = 1'b1;
    rst_e.vs = 1'b1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    ov_a = 1'b0;
    ov_b = 1'b0;
    #12;
    chk("reset_a", obs_a, rst_e);
    chk("reset_b", obs_b, rst_e);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      begin
        // Per-cycle reference check, strobe monitor and random overlay drive.
        while (!done) begin
          @(negedge clk);
          exp_a = model(n_a, HA_A, HFP_A, HS_A, HBP_A, VA_A, VFP_A, VS_A, VBP_A, off_a, ovp_a);
          exp_b = model(n_b, HA_B, HFP_B, HS_B, HBP_B, VA_B, VFP_B, VS_B, VBP_B, off_b, ovp_b);
          chk($sformatf("model_a n=%0d", n_a), obs_a, exp_a);
          chk($sformatf("model_b n=%0d", n_b), obs_b, exp_b);
          if (st_b) begin
            strobe_cnt++;
            chk("strobe_at_origin", {x_b, y_b}, 40'd0);
          end
          if (a_rand) ov_a = 1'($urandom_range(0, 1));
          if (b_rand) ov_b = 1'($urandom_range(0, 1));
        end
      end
      begin
        fork
          seq_a();
          seq_b();
        join
        done = 1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
